// File: rtl/ws2812_arbiter.sv
// Round-robin arbiter serialising up to four colour writers onto one ws2812 write port; optional index check via WS2812_ARB_RANGE_CHECK_EN.
// Latency: req sampled at an idle edge gives registered write/ack in the next cycle; one grant per 2+GAP cycles.
// Backpressure: req is a level held until ack; requests arriving while busy wait for the next idle edge.
module ws2812_arbiter #(
   parameter int NUM_REQ  = 2,
   parameter int NUM_LEDS = 4,
   parameter int GAP      = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_REQ-1:0]      req,
   input  logic [8*NUM_REQ-1:0]    req_led_num,
   input  logic [24*NUM_REQ-1:0]   req_rgb,
   output logic [NUM_REQ-1:0]      ack,
   output logic [NUM_REQ-1:0]      err,
   output logic [7:0]              led_num,
   output logic [23:0]             rgb_data,
   output logic                    write,
   output logic                    busy
);
   localparam int LW = (NUM_REQ > 2) ? 2 : 1;

   generate
      if (NUM_REQ < 2 || NUM_REQ > 4 || GAP < 0 || GAP > 15 || NUM_LEDS < 1 || NUM_LEDS > 256) begin : g_bad_param
         $error("ws2812_arbiter: parameter out of range");
      end
   endgenerate

   typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_GAP} state_t;

   state_t              state, state_nxt;
   logic [LW-1:0]       last, last_nxt, winner, cand;
   logic                found, reject;
   logic [3:0]          cnt, cnt_nxt;
   logic [7:0]          win_led, led_nxt;
   logic [23:0]         win_rgb, rgb_nxt;
   logic [NUM_REQ-1:0]  win_oh, ack_nxt, err_nxt;
   logic                write_nxt;

   // Rotating search: the requester just after the last winner has top priority.
   always_comb begin
      found  = 1'b0;
      winner = last;
      cand   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = LW'((32'(last) + 32'(k)) % 32'(NUM_REQ));
         if (!found && req[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   assign win_led = req_led_num[8*winner +: 8];
   assign win_rgb = req_rgb[24*winner +: 24];
   assign win_oh  = NUM_REQ'(1) << winner;

`ifdef WS2812_ARB_RANGE_CHECK_EN
   localparam logic [8:0] LED_LIM = 9'(NUM_LEDS);
   assign reject = ({1'b0, win_led} >= LED_LIM);
`else
   assign reject = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      last_nxt  = last;
      cnt_nxt   = cnt;
      ack_nxt   = '0;
      err_nxt   = '0;
      write_nxt = 1'b0;
      led_nxt   = led_num;
      rgb_nxt   = rgb_data;
      case (state)
         ST_IDLE: begin
            if (found) begin
               state_nxt = ST_WRITE;
               last_nxt  = winner;
               ack_nxt   = win_oh;
               if (reject) begin
                  err_nxt = win_oh;
               end else begin
                  write_nxt = 1'b1;
                  led_nxt   = win_led;
                  rgb_nxt   = win_rgb;
               end
            end
         end
         ST_WRITE: begin
            if (GAP > 0) begin
               state_nxt = ST_GAP;
               cnt_nxt   = 4'(GAP);
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_GAP: begin
            if (cnt <= 4'd1) begin
               state_nxt = ST_IDLE;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         last     <= LW'(NUM_REQ - 1);
         cnt      <= '0;
         ack      <= '0;
         err      <= '0;
         write    <= 1'b0;
         led_num  <= '0;
         rgb_data <= '0;
      end else begin
         state    <= state_nxt;
         last     <= last_nxt;
         cnt      <= cnt_nxt;
         ack      <= ack_nxt;
         err      <= err_nxt;
         write    <= write_nxt;
         led_num  <= led_nxt;
         rgb_data <= rgb_nxt;
      end
   end

   assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_ws2812_arbiter.sv
// Scoreboard bench for ws2812_arbiter: randomized requesters, per-requester expectation queues, cycle-level grant model.
module tb_ws2812_arbiter;
   localparam int NR = 3;
   localparam int NL = 4;
   localparam int GP = 2;
`ifdef WS2812_ARB_RANGE_CHECK_EN
   localparam bit RC = 1'b1;
`else
   localparam bit RC = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic [NR-1:0]    req = '0;
   logic [8*NR-1:0]  req_led_num = '0;
   logic [24*NR-1:0] req_rgb = '0;
   logic [NR-1:0]    ack, err;
   logic [7:0]       led_num;
   logic [23:0]      rgb_data;
   logic             write, busy;

   logic [1:0]       req_z = '0;
   logic [15:0]      req_led_z = {8'd2, 8'd1};
   logic [47:0]      req_rgb_z = {24'h000200, 24'h000100};
   logic [1:0]       ack_z, err_z;
   logic [7:0]       led_z;
   logic [23:0]      rgb_z;
   logic             write_z, busy_z;

   ws2812_arbiter #(.NUM_REQ(NR), .NUM_LEDS(NL), .GAP(GP)) u_dut (
      .clk(clk), .reset(reset), .req(req), .req_led_num(req_led_num), .req_rgb(req_rgb),
      .ack(ack), .err(err), .led_num(led_num), .rgb_data(rgb_data), .write(write), .busy(busy));

   ws2812_arbiter #(.NUM_REQ(2), .NUM_LEDS(NL), .GAP(0)) u_dut_z (
      .clk(clk), .reset(reset), .req(req_z), .req_led_num(req_led_z), .req_rgb(req_rgb_z),
      .ack(ack_z), .err(err_z), .led_num(led_z), .rgb_data(rgb_z), .write(write_z), .busy(busy_z));

   typedef struct packed {
      logic [7:0]  led;
      logic [23:0] rgb;
   } item_t;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   item_t       exp_q [NR][$];
   int          grant_log[$];
   int          grant_cyc[$];
   logic [NR-1:0] keep = '0;
   bit          rnd_on = 1'b0;
   int          raise_pct = 30;
   int          keep_pct = 30;

   task automatic issue(input int i, input logic [7:0] led, input logic [23:0] rgb);
      req_led_num[8*i +: 8] = led;
      req_rgb[24*i +: 24]   = rgb;
      req[i]                = 1'b1;
      exp_q[i].push_back(item_t'({led, rgb}));
   endtask

   // Requester agents: drop on ack, or immediately re-raise a fresh request.
   always @(negedge clk) begin
      if (!reset) begin
         for (int i = 0; i < NR; i++) begin
            if (req[i] && ack[i]) begin
               if (keep[i] || (rnd_on && $urandom_range(99) < keep_pct))
                  issue(i, 8'($urandom_range(5)), 24'($urandom));
               else
                  req[i] = 1'b0;
            end else if (!req[i] && rnd_on && $urandom_range(99) < raise_pct) begin
               issue(i, 8'($urandom_range(5)), 24'($urandom));
            end
         end
      end
   end

   // Reference model state: edge index, request vector seen at that edge, next edge the arbiter is free.
   int            cyc = 0;
   logic [NR-1:0] req_prev = '0;
   logic          rst_edge = 1'b1;
   int            next_idle = 0;
   int            last_m = NR - 1;
   logic [7:0]    m_led = '0;
   logic [23:0]   m_rgb = '0;

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      req_prev <= req;
      rst_edge <= reset;
   end

   function automatic int pick(input logic [NR-1:0] r, input int from);
      for (int k = 1; k <= NR; k++)
         if (r[(from + k) % NR]) return (from + k) % NR;
      return 0;
   endfunction

   always @(negedge clk) begin
      int          w;
      logic        exp_g, rej;
      item_t       it;
      logic [63:0] oh;
      if (reset || rst_edge) begin
         last_m = NR - 1; next_idle = 0; m_led = '0; m_rgb = '0;
      end else begin
         exp_g = (cyc >= next_idle) && (req_prev != '0);
         check("grant_present", 64'(ack != '0), 64'(exp_g));
         if (exp_g) begin
            w  = pick(req_prev, last_m);
            oh = 64'(1) << w;
            check("ack_winner", 64'(ack), oh);
            if (exp_q[w].size() == 0) begin
               check("data_queued", 64'(0), 64'(1));
            end else begin
               it  = exp_q[w].pop_front();
               rej = RC && (it.led >= NL);
               check("write_pulse", 64'(write), 64'(!rej));
               check("err_pulse", 64'(err), rej ? oh : 64'(0));
               if (!rej) begin m_led = it.led; m_rgb = it.rgb; end
            end
            last_m    = w;
            next_idle = cyc + 2 + GP;
            grant_log.push_back(w);
            grant_cyc.push_back(cyc);
         end else begin
            check("quiet", 64'({write, ack, err}), 64'(0));
         end
         check("led_num", 64'(led_num), 64'(m_led));
         check("rgb_data", 64'(rgb_data), 64'(m_rgb));
         check("busy", 64'(busy), 64'(cyc + 1 < next_idle));
      end
   end

   task automatic wait_log(input int k);
      int t = 0;
      while (grant_log.size() < k && t < 200) begin @(negedge clk); t++; end
      check("grant_count", 64'(grant_log.size() >= k), 64'(1));
      repeat (2) @(negedge clk);
   endtask

   task automatic drain();
      int  t = 0;
      bit  empty = 1'b0;
      while (!empty && t < 400) begin
         @(negedge clk); t++;
         empty = (req == '0);
         for (int i = 0; i < NR; i++) if (exp_q[i].size() != 0) empty = 1'b0;
      end
      check("drain", 64'(empty), 64'(1));
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk); reset = 1'b1;
      repeat (2) @(negedge clk); reset = 1'b0;
      grant_log.delete(); grant_cyc.delete();
   endtask

   initial begin
      int t, last_c, nw, exp_w;
      repeat (3) @(negedge clk);
      check("reset_main", {ack, err, write, led_num, rgb_data, busy}, 64'(0));
      check("reset_gap0", {ack_z, err_z, write_z, led_z, rgb_z, busy_z}, 64'(0));
      reset = 1'b0;
      @(negedge clk);

      // GAP=0 instance with both requests held continuously
      req_z = 2'b11; last_c = -1; nw = 0; exp_w = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (write_z) begin
            check("z_ack", 64'(ack_z), 64'(1) << exp_w);
            check("z_led", 64'(led_z), 64'(exp_w + 1));
            if (last_c >= 0) check("z_spacing", 64'(c - last_c), 64'(2));
            last_c = c; exp_w = 1 - exp_w; nw++;
         end
      end
      check("z_count", 64'(nw), 64'(6));
      req_z = 2'b00;

      // single request
      issue(1, 8'd2, 24'h000010);
      wait_log(1);
      check("single_winner", 64'(grant_log[0]), 64'(1));
      check("single_led", 64'(led_num), 64'(2));
      check("single_rgb", 64'(rgb_data), 64'(24'h000010));
      drain();

      // three-way contention, twice
      do_reset();
      for (int i = 0; i < NR; i++) issue(i, 8'(i), 24'(32'h10101 * (i + 1)));
      wait_log(3);
      for (int i = 0; i < NR; i++) issue(i, 8'(i), 24'(32'h20202 * (i + 1)));
      wait_log(6);
      for (int i = 0; i < 6; i++) check("cont_order", 64'(grant_log[i]), 64'(i % 3));
      check("cont_iv1", 64'(grant_cyc[1] - grant_cyc[0]), 64'(2 + GP));
      check("cont_iv2", 64'(grant_cyc[2] - grant_cyc[1]), 64'(2 + GP));
      drain();

      // fairness: requester 0 hogs, requester 1 asks once
      do_reset();
      keep[0] = 1'b1;
      issue(0, 8'd1, 24'h0000AA);
      t = 0;
      while (!ack[0] && t < 50) begin @(negedge clk); t++; end
      issue(1, 8'd2, 24'h0000BB);
      wait_log(3);
      check("fair_first", 64'(grant_log[0]), 64'(0));
      check("fair_second", 64'(grant_log[1]), 64'(1));
      keep[0] = 1'b0;
      drain();

      // reset during GAP with req[1] still pending
      do_reset();
      issue(0, 8'd3, 24'h123456);
      issue(1, 8'd1, 24'h654321);
      t = 0;
      while (!ack[0] && t < 50) begin @(negedge clk); t++; end
      check("rg_first_ack", 64'(ack), 64'(1));
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("rg_outputs_clear", {ack, err, write, led_num, rgb_data, busy}, 64'(0));
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rg_regrant", 64'({ack, write}), {60'd0, 3'b010, 1'b1});
      drain();

      // index at and just below the LED count
      do_reset();
      issue(2, 8'd4, 24'hABCDEF);
      wait_log(1);
      check("range_hi_led", 64'(led_num), RC ? 64'(0) : 64'(4));
      issue(2, 8'd3, 24'h0000FF);
      wait_log(2);
      check("range_ok_led", 64'(led_num), 64'(3));
      check("range_ok_rgb", 64'(rgb_data), 64'(24'h0000FF));
      drain();

      // randomized traffic
      rnd_on = 1'b1;
      repeat (1500) @(negedge clk);
      rnd_on = 1'b0;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      n_bad++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "timeout");
   end
endmodule

// File: doc/ws2812_arbiter.md
# ws2812_arbiter

Round-robin write-port arbiter in front of the `ws2812` LED driver core. It lets up to four independent requesters, such as an animation engine, a UART command decoder and a status-indicator block, update LED colours without colliding. It serialises their colour writes onto the core's single `led_num`/`rgb_data`/`write` port and enforces a minimum idle spacing between write pulses.

## Interface
- `NUM_REQ`, 2: number of requesters; legal range 2..4.
- `NUM_LEDS`, 4: LED count of the downstream `ws2812` instance; used only by the range check.
- `GAP`, 2: idle cycles forced after each grant; legal range 0..15.

- `clk`  in  1: system clock.
- `reset`  in  1: asynchronous, active-high reset.
- `req`  in  NUM_REQ: level request per requester; held high until that requester's `ack` is seen.
- `req_led_num`  in  8*NUM_REQ: packed LED index; requester i occupies [8i+7:8i]; stable while `req[i]` is high.
- `req_rgb`  in  24*NUM_REQ: packed colour; requester i occupies [24i+23:24i]; stable while `req[i]` is high.
- `ack`  out  NUM_REQ: one-cycle pulse, one-hot, marks the request as consumed.
- `err`  out  NUM_REQ: one-cycle pulse coincident with `ack` on a rejected request.
- `led_num`  out  8: to `ws2812.led_num`.
- `rgb_data`  out  24: to `ws2812.rgb_data`.
- `write`  out  1: to `ws2812.write`; one-cycle pulse.
- `busy`  out  1: high in every state except IDLE.

## Operation
- FSM states are IDLE, WRITE and GAP.
- **IDLE**: if any `req` bit is high at a clock edge, select the winner and move to WRITE.
  - Search starts at `last+1` and wraps modulo NUM_REQ.
  - On the same edge, register the winner's `led_num`/`rgb`, set `ack[winner]`, set `write`, and set `last = winner`.
- **WRITE** lasts exactly 1 cycle. During it, `write`=1 and `ack` is high for the winner only.
  - Next state is GAP if GAP>0, otherwise IDLE.
- **GAP**: a down-counter loaded with GAP. `req` is ignored. Move to IDLE when the counter reaches 1.
- `led_num`/`rgb_data` hold their last granted value until the next grant. They never glitch while `write`=0.
- Requesters must drop `req` on the edge where they sample `ack`=1. A `req` still high after that edge is a new request.
- Exactly one `ack` bit is ever high. `ack` and `write` are always coincident, except for rejected requests (see Configuration).
- Simultaneous requests are granted in rotating order. No requester waits more than NUM_REQ-1 grants.

## Timing
- Reset values:
  - state IDLE; `last`=NUM_REQ-1, so requester 0 wins the first contention.
  - All outputs 0: `ack`=0, `err`=0, `write`=0, `led_num`=0, `rgb_data`=0, `busy`=0.
- Latency: `req` sampled high at edge E gives `write`/`ack` high during cycle E..E+1, registered outputs only.
- Throughput: one grant per 2+GAP cycles, counted from IDLE edge to IDLE edge.
- GAP=0 is legal. Back-to-back grants are then 1 idle cycle apart, because WRITE→IDLE→WRITE takes 2 cycles per grant.
- Reset asserted mid-WRITE or mid-GAP clears state and outputs immediately, including `write`. A `req` still held is re-arbitrated after reset deassertion.
- A request arriving during WRITE/GAP waits. It is evaluated at the first IDLE edge.

## Configuration
- `WS2812_ARB_RANGE_CHECK_EN` **defined**: a winner with `led_num` ≥ NUM_LEDS is rejected.
  - `ack` and `err` pulse for that requester.
  - `write` stays 0, and `led_num`/`rgb_data` keep their previous values.
  - WRITE and GAP timing and the `last` update are unchanged.
- **Not defined**: no index check; every request is forwarded; `err` is constant 0.

## Test plan
- Single request: after reset, requester 1 sends led 2, `24'h00_00_10` → one `write` pulse with `led_num`=2, `rgb_data`=`24'h000010`; `ack[1]` coincident; `busy` high for 1+GAP cycles.
- Contention, NUM_REQ=3, GAP=2: all three `req` high together with leds 0/1/2 → grants in order 0,1,2 at 4-cycle intervals. Re-raising all three then grants 0,1,2 again.
- Fairness: requester 0 asserts `req` continuously (re-raising after each ack) while requester 1 requests once → requester 1 is granted no later than the second grant.
- GAP=0: two requesters held → `write` pulses every 2 cycles, alternating 0,1,0,1.
- Reset mid-GAP: assert `reset` 1 cycle after `write` → all outputs 0 immediately. A still-held `req[1]` is granted 1 cycle after `reset` falls.
- With `WS2812_ARB_RANGE_CHECK_EN`, NUM_LEDS=4: request led 4 → `ack`+`err` pulse, no `write`, `led_num` unchanged. Request led 3 → normal write, `err`=0.
